// File: rtl/lcd_bus_pkg.sv
// Shared constants and types for the HD44780-style 4-bit LCD bus responder.
package lcd_bus_pkg;

    localparam int unsigned AC_W          = 7;
    localparam logic [7:0]  CMD_CLEAR     = 8'h01;
    localparam int unsigned DDRAM_SET_BIT = 7;

    localparam logic [1:0] ST_HI_WAIT = 2'd0;
    localparam logic [1:0] ST_HI_ACT  = 2'd1;
    localparam logic [1:0] ST_LO_WAIT = 2'd2;
    localparam logic [1:0] ST_LO_ACT  = 2'd3;

    // Bus lines sampled together so they stay coherent through synchronization.
    typedef struct packed {
        logic       en;
        logic       rs;
        logic       rw;
        logic [3:0] data;
    } bus_sample_t;

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for a bundle of bus lines from the controller's domain.
module lcd_bus_sync #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/lcd_bus_responder.sv
// Device side of the 4-bit LCD bus: reassembles written bytes, tracks AC and busy time,
// and answers reads with {busy, AC} or host-supplied data.
module lcd_bus_responder
    import lcd_bus_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 37,
    parameter int unsigned CLEAR_CYCLES = 1520,
    parameter int unsigned CNT_W        = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rs_in,
    input  logic            rw_in,
    input  logic            enable_in,
    input  logic [3:0]      data_in,
    output logic [3:0]      data_out,
    output logic            data_oe,
    input  logic [7:0]      rd_data,
    output logic            byte_valid,
    output logic            byte_rs,
    output logic [7:0]      byte_data,
    output logic [AC_W-1:0] ac,
    output logic            busy,
    output logic            busy_err,
    output logic            proto_err
);

    bus_sample_t bus_raw;
    bus_sample_t bus_s;

    assign bus_raw = '{en: enable_in, rs: rs_in, rw: rw_in, data: data_in};

    lcd_bus_sync #(
        .WIDTH($bits(bus_sample_t))
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (bus_raw),
        .q_out(bus_s)
    );

    logic [1:0]      state_q, state_d;
    logic            en_prev_q, en_prev_d;
    logic            hi_rs_q, hi_rs_d;
    logic            hi_rw_q, hi_rw_d;
    logic [3:0]      hi_nib_q, hi_nib_d;
    logic [7:0]      rd_word_q, rd_word_d;
    logic [AC_W-1:0] ac_q, ac_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            byte_valid_q, byte_valid_d;
    logic            byte_rs_q, byte_rs_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic            busy_err_q, busy_err_d;
    logic            proto_err_q, proto_err_d;

    logic       en_rise;
    logic       en_fall;
    logic       start_hi;
    logic [7:0] new_byte;

    assign en_rise  = bus_s.en & ~en_prev_q;
    assign en_fall  = ~bus_s.en & en_prev_q;
    assign new_byte = {hi_nib_q, bus_s.data};
    assign busy     = (cnt_q != '0);

    always_comb begin
        state_d      = state_q;
        en_prev_d    = bus_s.en;
        hi_rs_d      = hi_rs_q;
        hi_rw_d      = hi_rw_q;
        hi_nib_d     = hi_nib_q;
        rd_word_d    = rd_word_q;
        ac_d         = ac_q;
        cnt_d        = cnt_q;
        byte_valid_d = 1'b0;
        byte_rs_d    = byte_rs_q;
        byte_data_d  = byte_data_q;
        busy_err_d   = 1'b0;
        proto_err_d  = 1'b0;
        start_hi     = 1'b0;

        if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        case (state_q)
            ST_HI_WAIT: begin
                if (en_rise) begin
                    start_hi = 1'b1;
                end
            end
            ST_HI_ACT: begin
                if (en_fall) begin
                    if (!hi_rw_q) begin
                        hi_nib_d = bus_s.data;
                    end
                    state_d = ST_LO_WAIT;
                end
            end
            ST_LO_WAIT: begin
                if (en_rise) begin
                    // A mismatched nibble is realigned as the start of a new byte.
                    if (bus_s.rs != hi_rs_q || bus_s.rw != hi_rw_q) begin
                        proto_err_d = 1'b1;
                        start_hi    = 1'b1;
                    end else begin
                        state_d = ST_LO_ACT;
                    end
                end
            end
            ST_LO_ACT: begin
                if (en_fall) begin
                    state_d = ST_HI_WAIT;
                    if (hi_rw_q) begin
                        if (hi_rs_q) begin
                            ac_d = ac_q + AC_W'(1);
                        end
                    end else begin
                        byte_valid_d = 1'b1;
                        byte_rs_d    = hi_rs_q;
                        byte_data_d  = new_byte;
                        busy_err_d   = busy;
                        cnt_d        = CNT_W'(BUSY_CYCLES);
                        if (hi_rs_q) begin
                            ac_d = ac_q + AC_W'(1);
                        end else if (new_byte == CMD_CLEAR) begin
                            ac_d  = '0;
                            cnt_d = CNT_W'(CLEAR_CYCLES);
                        end else if (new_byte[DDRAM_SET_BIT]) begin
                            ac_d = new_byte[AC_W-1:0];
                        end
                    end
                end
            end
            default: state_d = ST_HI_WAIT;
        endcase

        if (start_hi) begin
            state_d = ST_HI_ACT;
            hi_rs_d = bus_s.rs;
            hi_rw_d = bus_s.rw;
            if (bus_s.rw) begin
                rd_word_d = bus_s.rs ? rd_data : {busy, ac_q};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HI_WAIT;
            en_prev_q    <= 1'b0;
            hi_rs_q      <= 1'b0;
            hi_rw_q      <= 1'b0;
            hi_nib_q     <= '0;
            rd_word_q    <= '0;
            ac_q         <= '0;
            cnt_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_rs_q    <= 1'b0;
            byte_data_q  <= '0;
            busy_err_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_prev_q    <= en_prev_d;
            hi_rs_q      <= hi_rs_d;
            hi_rw_q      <= hi_rw_d;
            hi_nib_q     <= hi_nib_d;
            rd_word_q    <= rd_word_d;
            ac_q         <= ac_d;
            cnt_q        <= cnt_d;
            byte_valid_q <= byte_valid_d;
            byte_rs_q    <= byte_rs_d;
            byte_data_q  <= byte_data_d;
            busy_err_q   <= busy_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    always_comb begin
        data_out = 4'h0;
        data_oe  = 1'b0;
        if (hi_rw_q) begin
            if (state_q == ST_HI_ACT) begin
                data_oe  = 1'b1;
                data_out = rd_word_q[7:4];
            end else if (state_q == ST_LO_ACT) begin
                data_oe  = 1'b1;
                data_out = rd_word_q[3:0];
            end
        end
    end

    assign ac         = ac_q;
    assign byte_valid = byte_valid_q;
    assign byte_rs    = byte_rs_q;
    assign byte_data  = byte_data_q;
    assign busy_err   = busy_err_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: write table plus read, protocol and reset sequences.
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs_in = 1'b0;
    logic       rw_in = 1'b0;
    logic       enable_in = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic [3:0] data_out;
    logic       data_oe;
    logic [7:0] rd_data = 8'h00;
    logic       byte_valid;
    logic       byte_rs;
    logic [7:0] byte_data;
    logic [6:0] ac;
    logic       busy;
    logic       busy_err;
    logic       proto_err;

    lcd_bus_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_in     (rs_in),
        .rw_in     (rw_in),
        .enable_in (enable_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .rd_data   (rd_data),
        .byte_valid(byte_valid),
        .byte_rs   (byte_rs),
        .byte_data (byte_data),
        .ac        (ac),
        .busy      (busy),
        .busy_err  (busy_err),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Event counters sampled on the falling edge.
    int          bv_cnt  = 0;
    int          pe_cnt  = 0;
    int          be_cnt  = 0;
    int          run_cnt = 0;
    int          last_run = 0;
    logic        last_rs = 1'b0;
    logic [7:0]  last_data = 8'h00;

    always @(negedge clk) begin
        if (byte_valid) begin
            bv_cnt    = bv_cnt + 1;
            last_rs   = byte_rs;
            last_data = byte_data;
        end
        if (proto_err) pe_cnt = pe_cnt + 1;
        if (busy_err) be_cnt = be_cnt + 1;
        if (busy) begin
            run_cnt = run_cnt + 1;
        end else if (run_cnt != 0) begin
            last_run = run_cnt;
            run_cnt  = 0;
        end
    end

    typedef struct {
        logic        rs;
        logic [7:0]  data;
        logic [6:0]  exp_ac;
        int          exp_run;
    } wr_vec_t;

    wr_vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nibble(input logic rs, input logic rw, input logic [3:0] d);
        rs_in     = rs;
        rw_in     = rw;
        data_in   = d;
        enable_in = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        enable_in = 1'b0;
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic write_byte(input logic rs, input logic [7:0] b);
        nibble(rs, 1'b0, b[7:4]);
        nibble(rs, 1'b0, b[3:0]);
    endtask

    task automatic read_byte(input logic rs, input logic [7:0] exp);
        rs_in     = rs;
        rw_in     = 1'b1;
        data_in   = 4'h0;
        enable_in = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rd_oe_early", data_oe, 1'b0);
        @(posedge clk);
        #2;
        check("rd_oe_latency", data_oe, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        check("rd_hi_nibble", data_out, exp[7:4]);
        enable_in = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("rd_oe_lo_wait", data_oe, 1'b0);
        enable_in = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("rd_lo_nibble", data_out, exp[3:0]);
        check("rd_oe_lo_act", data_oe, 1'b1);
        enable_in = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("rd_oe_idle", data_oe, 1'b0);
        rw_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        check("busy_timeout", busy, 1'b0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        int bv_before;

        vecs[0] = '{rs: 1'b1, data: 8'hA5, exp_ac: 7'h01, exp_run: 37};
        vecs[1] = '{rs: 1'b1, data: 8'h33, exp_ac: 7'h02, exp_run: 37};
        vecs[2] = '{rs: 1'b0, data: 8'h85, exp_ac: 7'h05, exp_run: 37};
        vecs[3] = '{rs: 1'b0, data: 8'h01, exp_ac: 7'h00, exp_run: 1520};
        vecs[4] = '{rs: 1'b0, data: 8'hC0, exp_ac: 7'h40, exp_run: 37};
        vecs[5] = '{rs: 1'b0, data: 8'h0C, exp_ac: 7'h40, exp_run: 37};
        vecs[6] = '{rs: 1'b0, data: 8'hFF, exp_ac: 7'h7F, exp_run: 37};
        vecs[7] = '{rs: 1'b1, data: 8'h41, exp_ac: 7'h00, exp_run: 37};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_data_oe", data_oe, 1'b0);
        check("rst_data_out", data_out, 4'h0);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_byte_data", byte_data, 8'h00);
        check("rst_ac", ac, 7'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_errs", {busy_err, proto_err}, 2'b00);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Write table
        for (int i = 0; i < 8; i++) begin
            bv_before = bv_cnt;
            write_byte(vecs[i].rs, vecs[i].data);
            wait_idle();
            check("wr_bv_count", bv_cnt - bv_before, 1);
            check("wr_byte_rs", last_rs, vecs[i].rs);
            check("wr_byte_data", last_data, vecs[i].data);
            check("wr_ac", ac, vecs[i].exp_ac);
            check("wr_busy_len", last_run, vecs[i].exp_run);
        end
        check("no_busy_err_yet", be_cnt, 0);

        // Status read while busy after DDRAM set to 0x40
        write_byte(1'b0, 8'hC0);
        read_byte(1'b0, 8'hC0);
        wait_idle();
        check("status_rd_ac", ac, 7'h40);

        // AC wrap then data read
        write_byte(1'b0, 8'hFF);
        wait_idle();
        check("ac_set_7f", ac, 7'h7F);
        write_byte(1'b1, 8'h41);
        wait_idle();
        check("ac_wrap", ac, 7'h00);
        bv_before = bv_cnt;
        rd_data = 8'h3C;
        read_byte(1'b1, 8'h3C);
        rd_data = 8'h00;
        check("data_rd_ac_inc", ac, 7'h01);
        check("rd_no_bv", bv_cnt - bv_before, 0);

        // Clear then a second write while still busy
        write_byte(1'b0, 8'h01);
        write_byte(1'b0, 8'h06);
        wait_idle();
        check("busy_err_count", be_cnt, 1);
        check("busy_reload_len", last_run, 24 + 37);
        check("clr_then_entry_ac", ac, 7'h00);
        check("clr_then_entry_data", last_data, 8'h06);

        // Protocol realignment
        bv_before = bv_cnt;
        nibble(1'b0, 1'b0, 4'h4);
        nibble(1'b1, 1'b0, 4'h4);
        check("proto_err_pulse", pe_cnt, 1);
        check("proto_no_bv", bv_cnt - bv_before, 0);
        nibble(1'b1, 1'b0, 4'h8);
        wait_idle();
        check("proto_bv", bv_cnt - bv_before, 1);
        check("proto_byte_data", last_data, 8'h48);
        check("proto_byte_rs", last_rs, 1'b1);
        check("proto_ac", ac, 7'h01);

        // Reset between nibbles discards the partial byte
        write_byte(1'b1, 8'h10);
        nibble(1'b1, 1'b0, 4'h7);
        check("pre_rst_ac", ac, 7'h02);
        check("pre_rst_busy", busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_ac", ac, 7'h00);
        check("arst_busy", busy, 1'b0);
        check("arst_byte_data", byte_data, 8'h00);
        check("arst_byte_rs", byte_rs, 1'b0);
        check("arst_data_oe", data_oe, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        bv_before = bv_cnt;
        write_byte(1'b1, 8'h5A);
        wait_idle();
        check("post_rst_bv", bv_cnt - bv_before, 1);
        check("post_rst_data", last_data, 8'h5A);
        check("post_rst_ac", ac, 7'h01);
        check("post_rst_busy_len", last_run, 37);
        check("final_busy_err_count", be_cnt, 1);
        check("final_proto_err_count", pe_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
